// File: rtl/frame_sync_pkg.sv
// -----------------------------------------------------------------------------
// frame_sync_pkg
// Shared definitions for the frame synchronisation monitor:
//   - fs_state_e     : monitor state (IDLE / ACTIVE)
//   - H_ACTIVE_DEF   : default active pixels per line
//   - V_ACTIVE_DEF   : default active lines per frame
//   - FRAME_CNT_W    : width of the completed-frame counter
// -----------------------------------------------------------------------------
package frame_sync_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } fs_state_e;

    localparam int H_ACTIVE_DEF = 1280;
    localparam int V_ACTIVE_DEF = 720;
    localparam int FRAME_CNT_W  = 16;

endpackage

// File: rtl/frame_sync_detect.sv
// -----------------------------------------------------------------------------
// frame_sync_detect
// Passive monitor on an AXI4-Stream video path. It tracks pixel/line position
// of observed transfers against the active resolution and pulses frame_done
// when the last pixel of a complete frame is transferred. It never drives
// ready; it only watches handshakes.
//
// Configuration macro:
//   FRAME_SYNC_STRICT_EN  defined  : line length is checked; tlast on the wrong
//                                    pixel, or pixel H_ACTIVE without tlast,
//                                    aborts the frame with frame_err.
//                         undefined: any tlast ends a line; frame_err only
//                                    flags an early start-of-frame.
//
// Ports:
//   clk         in   video stream clock
//   n_rst       in   asynchronous active-low reset
//   s_tvalid    in   observed stream valid
//   s_tready    in   observed stream ready (xfer = valid & ready)
//   s_tuser     in   start-of-frame marker
//   s_tlast     in   end-of-line marker
//   frame_done  out  1-cycle pulse, complete well-formed frame ended
//   frame_err   out  1-cycle pulse, framing violation
//   in_frame    out  high while inside a frame
//   frame_cnt   out  completed frame count, wraps at 0xFFFF
// -----------------------------------------------------------------------------
module frame_sync_detect
    import frame_sync_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   s_tvalid,
    input  logic                   s_tready,
    input  logic                   s_tuser,
    input  logic                   s_tlast,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic                   in_frame,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int PIX_W  = $clog2(H_ACTIVE + 1);
    localparam int LINE_W = $clog2(V_ACTIVE + 1);

    localparam logic [PIX_W-1:0]       PIX_ZERO  = {PIX_W{1'b0}};
    localparam logic [PIX_W-1:0]       PIX_ONE   = PIX_W'(1);
    localparam logic [PIX_W-1:0]       PIX_LAST  = PIX_W'(H_ACTIVE);
    localparam logic [LINE_W-1:0]      LINE_ZERO = {LINE_W{1'b0}};
    localparam logic [LINE_W-1:0]      LINE_ONE  = LINE_W'(1);
    localparam logic [LINE_W-1:0]      LINE_LAST = LINE_W'(V_ACTIVE - 1);
    localparam logic [FRAME_CNT_W-1:0] FCNT_ONE  = FRAME_CNT_W'(1);

    fs_state_e               state_r,      state_s;
    logic [PIX_W-1:0]        pix_cnt_r,    pix_cnt_s;
    logic [LINE_W-1:0]       line_cnt_r,   line_cnt_s;
    logic [FRAME_CNT_W-1:0]  frame_cnt_r,  frame_cnt_s;
    logic                    frame_done_r, frame_done_s;
    logic                    frame_err_r,  frame_err_s;

    logic                    xfer_s;
    logic                    take_beat_s;
    logic                    sof_err_s;
    logic                    len_err_s;
    logic                    eol_s;
    logic [PIX_W-1:0]        pix_num_s;
    logic [LINE_W-1:0]       line_num_s;

    // Position of the current beat; an SOF beat always restarts at pixel 1 of
    // line 0 so a simultaneous tlast is judged against pixel 1.
    always_comb begin
        pix_num_s  = PIX_ONE;
        line_num_s = LINE_ZERO;
        if (s_tuser) begin
            pix_num_s  = PIX_ONE;
            line_num_s = LINE_ZERO;
        end else if (pix_cnt_r == PIX_LAST) begin
            // Only reachable in the relaxed build: saturate instead of wrapping.
            pix_num_s  = PIX_LAST;
            line_num_s = line_cnt_r;
        end else begin
            pix_num_s  = pix_cnt_r + PIX_ONE;
            line_num_s = line_cnt_r;
        end
    end

    // Line-end / line-length classification of the current beat.
`ifdef FRAME_SYNC_STRICT_EN
    always_comb begin
        eol_s     = s_tlast & (pix_num_s == PIX_LAST);
        len_err_s = s_tlast ^ (pix_num_s == PIX_LAST);
    end
`else
    always_comb begin
        eol_s     = s_tlast;
        len_err_s = 1'b0;
    end
`endif

    // Next-state, counter and pulse logic.
    always_comb begin
        state_s      = state_r;
        pix_cnt_s    = pix_cnt_r;
        line_cnt_s   = line_cnt_r;
        frame_cnt_s  = frame_cnt_r;
        frame_done_s = 1'b0;
        frame_err_s  = 1'b0;
        take_beat_s  = 1'b0;
        sof_err_s    = 1'b0;
        xfer_s       = s_tvalid & s_tready;

        case (state_r)
            IDLE: begin
                // Beats before an SOF (mid-frame join) are ignored.
                take_beat_s = xfer_s & s_tuser;
                sof_err_s   = 1'b0;
            end
            ACTIVE: begin
                take_beat_s = xfer_s;
                sof_err_s   = xfer_s & s_tuser;
            end
            default: begin
                take_beat_s = 1'b0;
                sof_err_s   = 1'b0;
            end
        endcase

        if (take_beat_s) begin
            if (len_err_s) begin
                state_s     = IDLE;
                pix_cnt_s   = PIX_ZERO;
                line_cnt_s  = LINE_ZERO;
                frame_err_s = 1'b1;
            end else if (eol_s) begin
                pix_cnt_s   = PIX_ZERO;
                frame_err_s = sof_err_s;
                if (line_num_s == LINE_LAST) begin
                    // sof_err_s implies line 0, which is never the last line,
                    // so done and err cannot coincide here.
                    state_s      = IDLE;
                    line_cnt_s   = LINE_ZERO;
                    frame_done_s = 1'b1;
                    frame_cnt_s  = frame_cnt_r + FCNT_ONE;
                end else begin
                    state_s    = ACTIVE;
                    line_cnt_s = line_num_s + LINE_ONE;
                end
            end else begin
                state_s     = ACTIVE;
                pix_cnt_s   = pix_num_s;
                line_cnt_s  = line_num_s;
                frame_err_s = sof_err_s;
            end
        end else begin
            state_s = state_r;
        end
    end

    // State, counters and output pulse registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r      <= IDLE;
            pix_cnt_r    <= PIX_ZERO;
            line_cnt_r   <= LINE_ZERO;
            frame_cnt_r  <= {FRAME_CNT_W{1'b0}};
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            pix_cnt_r    <= pix_cnt_s;
            line_cnt_r   <= line_cnt_s;
            frame_cnt_r  <= frame_cnt_s;
            frame_done_r <= frame_done_s;
            frame_err_r  <= frame_err_s;
        end
    end

    assign frame_done = frame_done_r;
    assign frame_err  = frame_err_r;
    assign in_frame   = (state_r == ACTIVE);
    assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_frame_sync_detect.sv
// -----------------------------------------------------------------------------
// tb_frame_sync_detect
// Self-checking bench for frame_sync_detect with H_ACTIVE=4, V_ACTIVE=3.
// Expectations for the strict / relaxed build follow FRAME_SYNC_STRICT_EN.
// -----------------------------------------------------------------------------
module tb_frame_sync_detect;

    localparam int H = 4;
    localparam int V = 3;
`ifdef FRAME_SYNC_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        n_rst;
    logic        s_tvalid, s_tready, s_tuser, s_tlast;
    logic        frame_done, frame_err, in_frame;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: position in frame as plain integers.
    bit m_active = 1'b0;
    int m_pix    = 0;
    int m_line   = 0;
    int m_fcnt   = 0;
    bit m_done   = 1'b0;
    bit m_err    = 1'b0;

    typedef struct {
        bit v, r, u, l;
        bit e_done, e_err, e_in;
        int e_cnt;
    } vec_t;

    vec_t tbl[16];

    frame_sync_detect #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tuser    (s_tuser),
        .s_tlast    (s_tlast),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .in_frame   (in_frame),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_pix = 0; m_line = 0; m_fcnt = 0;
        m_done = 1'b0; m_err = 1'b0;
    endtask

    // One clock edge of the model, from the frame-format rules.
    task automatic model_beat(input bit v, input bit r, input bit u, input bit l);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (v && r) begin
            if (u) begin
                if (m_active) m_err = 1'b1;
                m_active = 1'b1;
                m_pix    = 0;
                m_line   = 0;
            end
            if (m_active) begin
                m_pix++;
                if (STRICT && (l != (m_pix == H))) begin
                    m_err    = 1'b1;
                    m_active = 1'b0;
                end else if (l) begin
                    m_pix = 0;
                    m_line++;
                    if (m_line == V) begin
                        m_done   = 1'b1;
                        m_fcnt   = (m_fcnt + 1) % 65536;
                        m_active = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit v, input bit r, input bit u, input bit l, input string tag);
        @(negedge clk);
        s_tvalid = v; s_tready = r; s_tuser = u; s_tlast = l;
        @(posedge clk);
        model_beat(v, r, u, l);
        #1;
        check({tag, ".done"},  frame_done, m_done);
        check({tag, ".err"},   frame_err,  m_err);
        check({tag, ".infrm"}, in_frame,   m_active);
        check({tag, ".cnt"},   frame_cnt,  m_fcnt);
    endtask

    task automatic frame_beats(input int first, input int last_b, input string tag);
        for (int b = first; b <= last_b; b++)
            step(1'b1, 1'b1, b == 0, (b % H) == (H - 1), tag);
    endtask

    initial begin
        int idx;
        int nb;
        int cyc;
        int pos;
        bit v, r, u, l;
        int pe;

        // Table: stray beat before SOF, clean frame with a stalled beat, idle.
        idx = 0;
        tbl[idx++] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        for (int b = 0; b < 12; b++) begin
            tbl[idx++] = '{1'b1, 1'b1, b == 0, (b % 4) == 3, b == 11, 1'b0, b != 11, (b == 11) ? 1 : 0};
            if (b == 5) tbl[idx++] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        end
        tbl[idx++] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[idx++] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};

        // Reset state.
        n_rst = 1'b0; s_tvalid = 1'b0; s_tready = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst.done",  frame_done, 0);
        check("rst.err",   frame_err,  0);
        check("rst.infrm", in_frame,   0);
        check("rst.cnt",   frame_cnt,  0);
        @(negedge clk);
        n_rst = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].r, tbl[i].u, tbl[i].l, "tbl");
            check($sformatf("tbl%0d.done", i),  frame_done, tbl[i].e_done);
            check($sformatf("tbl%0d.err", i),   frame_err,  tbl[i].e_err);
            check($sformatf("tbl%0d.infrm", i), in_frame,   tbl[i].e_in);
            check($sformatf("tbl%0d.cnt", i),   frame_cnt,  tbl[i].e_cnt);
        end

        // Short line: tlast on beat 2.
        frame_beats(0, 1, "short");
        step(1'b1, 1'b1, 1'b0, 1'b1, "short");
        check("short.err",   frame_err, STRICT ? 1 : 0);
        check("short.infrm", in_frame,  STRICT ? 0 : 1);
`ifdef FRAME_SYNC_STRICT_EN
        frame_beats(0, 11, "short_next");
`else
        frame_beats(4, 11, "short_next");
`endif
        check("short_next.done", frame_done, 1);
        check("short_next.cnt",  frame_cnt,  2);

        // Early SOF on beat 6, then a complete restarted frame.
        frame_beats(0, 5, "esof");
        step(1'b1, 1'b1, 1'b1, 1'b0, "esof");
        check("esof.err",   frame_err,  1);
        check("esof.infrm", in_frame,   1);
        frame_beats(1, 10, "esof_tail");
        check("esof_tail.nodone", frame_done, 0);
        frame_beats(11, 11, "esof_end");
        check("esof_end.done", frame_done, 1);
        check("esof_end.cnt",  frame_cnt,  3);

        // Back-pressure: ready low on alternate cycles, random valid gaps.
        nb = 0; cyc = 0;
        while (nb < 12 && cyc < 200) begin
            v = ($urandom_range(0, 3) != 0);
            r = (cyc % 2) == 0;
            step(v, r, nb == 0, (nb % H) == (H - 1), "bp");
            if (v && r) nb++;
            cyc++;
        end
        check("bp.budget", nb, 12);
        check("bp.done",   frame_done, 1);
        check("bp.cnt",    frame_cnt,  4);

        // tuser and tlast together mid-frame.
        frame_beats(0, 1, "ul");
        step(1'b1, 1'b1, 1'b1, 1'b1, "ul");
        check("ul.err",   frame_err,  1);
        check("ul.done",  frame_done, 0);
        check("ul.infrm", in_frame,   STRICT ? 0 : 1);

        // Randomized traffic with rare stray SOF / flipped tlast.
        pos = 0;
        for (int c = 0; c < 800; c++) begin
            v  = ($urandom_range(0, 4) != 0);
            r  = ($urandom_range(0, 3) != 0);
            u  = (pos == 0) || ($urandom_range(0, 59) == 0);
            pe = u ? 0 : pos;
            l  = ((pe % H) == (H - 1)) ^ ($urandom_range(0, 29) == 0);
            step(v, r, u, l, "rnd");
            if (v && r) pos = (pe + 1) % (H * V);
        end

        // Reset asserted mid-frame, then beats without SOF are ignored.
        @(negedge clk);
        n_rst = 1'b0;
        s_tvalid = 1'b0;
        #1;
        check("rstmid.done",  frame_done, 0);
        check("rstmid.err",   frame_err,  0);
        check("rstmid.infrm", in_frame,   0);
        check("rstmid.cnt",   frame_cnt,  0);
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
        frame_beats(0, 4, "pre");
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("rst5.infrm", in_frame,  0);
        check("rst5.cnt",   frame_cnt, 0);
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
        frame_beats(5, 11, "after_rst");
        check("after_rst.infrm", in_frame,   0);
        check("after_rst.done",  frame_done, 0);

        // Counter wrap from 0xFFFF.
        frame_beats(0, 10, "wrap");
        @(negedge clk);
        s_tvalid = 1'b0;
        force dut.frame_cnt_r = 16'hFFFF;
        #1;
        release dut.frame_cnt_r;
        m_fcnt = 65535;
        #1;
        check("wrap.pre", frame_cnt, 65535);
        frame_beats(11, 11, "wrap_end");
        check("wrap.done", frame_done, 1);
        check("wrap.cnt",  frame_cnt,  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_sync_detect.md
# frame_sync_detect

Passive monitor on the camera AXI4-Stream video path that tracks pixel and line position against the configured active resolution. It emits a single-cycle `frame_done` pulse when the final pixel of a complete frame is transferred. `frame_done` is the trigger that drives the ping-pong frame-role toggle directly downstream. It never back-pressures the stream: it only observes handshakes.

## Interface
- `H_ACTIVE`, 1280, pixels (beats) per line; legal range 2..65535.
- `V_ACTIVE`, 720, lines per frame; legal range 2..65535.
- `clk`  in  1  video stream clock.
- `n_rst`  in  1  asynchronous, active-low reset.
- `s_tvalid`  in  1  observed stream valid.
- `s_tready`  in  1  observed stream ready; a transfer (xfer) is `s_tvalid & s_tready`.
- `s_tuser`  in  1  start-of-frame marker on the first beat.
- `s_tlast`  in  1  end-of-line marker.
- `frame_done`  out  1  one-cycle pulse; a complete, well-formed frame ended.
- `frame_err`  out  1  one-cycle pulse; framing violation detected.
- `in_frame`  out  1  high while the state is ACTIVE.
- `frame_cnt`  out  16  count of completed frames; wraps 0xFFFF to 0.

## Operation
- States:
  - IDLE: waiting for SOF.
  - ACTIVE: inside a frame.
- Internal counters:
  - `pix_cnt`: width clog2(H_ACTIVE+1).
  - `line_cnt`: width clog2(V_ACTIVE+1).
- Reset values:
  - State IDLE.
  - `pix_cnt`, `line_cnt`, `frame_cnt` all 0.
  - `frame_done`, `frame_err`, `in_frame` all 0.
- Cycles without an xfer change nothing. Pulses deassert on the next cycle.
- IDLE:
  - xfer with `s_tuser=1` → ACTIVE. That beat counts as pixel 1 of line 0.
  - xfer with `s_tuser=0` is ignored (mid-frame join after reset).
- ACTIVE, xfer with `s_tuser=1` (early SOF):
  - Pulse `frame_err`.
  - Restart the frame: `pix_cnt=1`, `line_cnt=0`. Stay ACTIVE.
- ACTIVE, xfer with `s_tlast=1`, beat is pixel H_ACTIVE:
  - `pix_cnt←0`, `line_cnt++`.
  - If this was line V_ACTIVE−1: pulse `frame_done`, `frame_cnt++`, go to IDLE.
- ACTIVE, line-length violation (strict mode only):
  - Cases: `s_tlast` on a pixel other than H_ACTIVE, or pixel H_ACTIVE without `s_tlast`.
  - Action: pulse `frame_err`, go to IDLE. `frame_cnt` is unchanged.
- Simultaneous events:
  - `s_tuser` and `s_tlast` on the same beat: the early-SOF rule takes precedence. The tlast is then evaluated against `pix_cnt=1`.
  - `frame_done` and `frame_err` are never high in the same cycle.
- An SOF arriving on the cycle after `frame_done` is accepted normally; there is no dead cycle.

## Timing
- All outputs are registered.
- `frame_done` and `frame_err` assert exactly 1 cycle after the causing xfer edge.
- `in_frame` rises 1 cycle after the SOF xfer and falls 1 cycle after the final or error beat.
- `n_rst` assertion mid-frame:
  - Immediately forces IDLE, clears the counters and `frame_cnt`, and drops any pulse in flight.
  - After deassertion, a new SOF is required.

## Configuration
- `FRAME_SYNC_STRICT_EN` defined:
  - Line-length checking is active as described above.
- `FRAME_SYNC_STRICT_EN` undefined:
  - Every `s_tlast` xfer in ACTIVE ends a line regardless of `pix_cnt`.
  - The pixel-H_ACTIVE-without-tlast check is removed.
  - `frame_err` pulses only on early SOF.

## Structure
- Shared package `frame_sync_pkg`:
  - State enum `{IDLE, ACTIVE}`.
  - Default `H_ACTIVE`/`V_ACTIVE` constants.
  - `FRAME_CNT_W = 16`.
- Single flat module; no sub-module warranted.

## Test plan
All scenarios use H_ACTIVE=4, V_ACTIVE=3.
- **Clean frame:** 12 contiguous xfers (tuser on beat 0, tlast on beats 3/7/11) → `frame_done` high exactly 1 cycle after beat 11; `frame_cnt` 0→1; `frame_err` never asserts.
- **Back-pressure:** same frame with `s_tready` low on alternate cycles and random `s_tvalid` gaps → identical result; non-xfer beats are not counted.
- **Short line, strict build:** tlast on beat 2 → `frame_err` 1 cycle later; `in_frame`=0; the next full frame gives `frame_done` with `frame_cnt`=1.
- **Short line, non-strict build:** tlast on beat 2 → no `frame_err`; 3 tlasts → `frame_done`.
- **Early SOF:** tuser reasserted on beat 6 → `frame_err` pulse; `frame_done` follows 12 beats after beat 6.
- **Reset and wrap:**
  - Assert `n_rst` on beat 5 → all outputs 0; beats without tuser are ignored after release.
  - Preload `frame_cnt`=0xFFFF via 65535 frames (or force) → the next frame wraps it to 0.
